game_step_scheduler: RTL and testbench

Frame-synchronous scheduler for the Snake datapath. It watches the scan-line counter from `vga_sync` and issues one game-step request every `speed+1` frames, always at the start of vertical blank. While a step is in progress it grants the shared board RAM to the game logic; at all other times the video renderer owns the RAM. It sits between `vga_sync`, the game-logic FSM, the pixel renderer and the board RAM.

---
 rtl/game_step_scheduler.sv | 117 +++++++++++
 tb/tb_game_step_scheduler.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_step_scheduler.sv
`default_nettype none
// ============================================================================
// game_step_scheduler : issues one game step every speed+1 frames at the start
//                       of vertical blank and arbitrates the shared board RAM.
// Revision            : 1.0
// ============================================================================
module game_step_scheduler #(
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        y,
  input  logic              pause,
  input  logic [3:0]        speed,
  input  logic              step_ack,
  input  logic              clr_overrun,
  input  logic [ADDR_W-1:0] rd_addr_vid,
  input  logic [ADDR_W-1:0] addr_game,
  input  logic              we_game,
  input  logic [DATA_W-1:0] wdata_game,
  output logic              step_req,
  output logic              grant,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [3:0]        frame_cnt,
  output logic [15:0]       step_count,
  output logic              overrun
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    STEP = 1'b1
  } state_t;

  localparam logic [9:0] C_V_ACTIVE = 10'(V_ACTIVE);

  state_t      state_q, state_d;
  logic        blank_q;
  logic [3:0]  frame_cnt_q, frame_cnt_d;
  logic [15:0] step_count_q, step_count_d;
  logic        overrun_q, overrun_d;

  logic        blank;
  logic        vblank_start;
  logic        active_start;

  assign blank        = (y >= C_V_ACTIVE);
  assign vblank_start = blank & ~blank_q;
  assign active_start = ~blank & blank_q;

  // blank_q resets high so a reset taken inside blanking cannot fake an edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      blank_q      <= 1'b1;
      frame_cnt_q  <= 4'd0;
      step_count_q <= 16'd0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      blank_q      <= blank;
      frame_cnt_q  <= frame_cnt_d;
      step_count_q <= step_count_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    step_count_d = step_count_q;
    overrun_d    = overrun_q;

    if (clr_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // >= so that lowering speed below the current count fires at once.
        if (vblank_start && !pause) begin
          if (frame_cnt_q >= speed) begin
            frame_cnt_d = 4'd0;
            state_d     = STEP;
          end else begin
            frame_cnt_d = frame_cnt_q + 4'd1;
          end
        end
      end
      STEP: begin
        if (active_start) begin
          overrun_d = 1'b1;
        end
        if (step_ack) begin
          state_d      = IDLE;
          step_count_d = step_count_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign step_req   = (state_q == STEP);
  assign grant      = (state_q == STEP);
  assign frame_cnt  = frame_cnt_q;
  assign step_count = step_count_q;
  assign overrun    = overrun_q;

  assign ram_addr  = grant ? addr_game : rd_addr_vid;
  assign ram_we    = grant & we_game;
  assign ram_wdata = wdata_game;

endmodule
`default_nettype wire

// File: tb/tb_game_step_scheduler.sv
`default_nettype none
// ============================================================================
// tb_game_step_scheduler : directed and randomized checks of the step scheduler
//                          against a frame-level reference model.
// Revision               : 1.0
// ============================================================================
module tb_game_step_scheduler;

  localparam int V_ACTIVE = 480;
  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 4;
  localparam int LINES    = 525;

  logic              clk = 1'b0;
  logic              reset;
  logic [9:0]        y;
  logic              pause;
  logic [3:0]        speed;
  logic              step_ack;
  logic              clr_overrun;
  logic [ADDR_W-1:0] rd_addr_vid;
  logic [ADDR_W-1:0] addr_game;
  logic              we_game;
  logic [DATA_W-1:0] wdata_game;
  logic              step_req;
  logic              grant;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [3:0]        frame_cnt;
  logic [15:0]       step_count;
  logic              overrun;

  game_step_scheduler #(
    .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .reset(reset), .y(y), .pause(pause), .speed(speed),
    .step_ack(step_ack), .clr_overrun(clr_overrun),
    .rd_addr_vid(rd_addr_vid), .addr_game(addr_game),
    .we_game(we_game), .wdata_game(wdata_game),
    .step_req(step_req), .grant(grant), .ram_addr(ram_addr),
    .ram_we(ram_we), .ram_wdata(ram_wdata), .frame_cnt(frame_cnt),
    .step_count(step_count), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whether a step is outstanding, frames waited, steps done.
  bit          model_valid = 1'b0;
  bit          m_was_blank = 1'b1;
  bit          m_busy      = 1'b0;
  int          m_frames    = 0;
  logic [15:0] m_steps     = 16'd0;
  bit          m_ovr       = 1'b0;

  always @(posedge clk) begin
    bit in_blank;
    in_blank = (int'(y) >= V_ACTIVE);
    if (reset) begin
      m_was_blank = 1'b1;
      m_busy      = 1'b0;
      m_frames    = 0;
      m_steps     = 16'd0;
      m_ovr       = 1'b0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_busy && !in_blank && m_was_blank) m_ovr = 1'b1;
      else if (clr_overrun)                   m_ovr = 1'b0;
      if (m_busy) begin
        if (step_ack) begin
          m_busy  = 1'b0;
          m_steps = m_steps + 16'd1;
        end
      end else if (in_blank && !m_was_blank && !pause) begin
        if (m_frames >= int'(speed)) begin
          m_frames = 0;
          m_busy   = 1'b1;
        end else begin
          m_frames = m_frames + 1;
        end
      end
      m_was_blank = in_blank;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("step_req",   32'(step_req),   32'(m_busy));
      chk("grant",      32'(grant),      32'(m_busy));
      chk("frame_cnt",  32'(frame_cnt),  32'(m_frames));
      chk("step_count", 32'(step_count), 32'(m_steps));
      chk("overrun",    32'(overrun),    32'(m_ovr));
      chk("ram_addr",   32'(ram_addr),   32'(m_busy ? addr_game : rd_addr_vid));
      chk("ram_we",     32'(ram_we),     32'(m_busy && we_game));
      chk("ram_wdata",  32'(ram_wdata),  32'(wdata_game));
    end
  end

  // Stimulus state
  int vs_seen   = 0;
  int rises[$];
  bit prev_req  = 1'b0;
  int wait_cnt  = 0;
  int ack_lat   = 5;
  bit hold_ack  = 1'b0;
  bit spurious  = 1'b0;
  bit rnd_bus   = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    clr_overrun = 1'b0;
    if (step_ack) begin
      step_ack = 1'b0;
    end else if (step_req && !hold_ack) begin
      wait_cnt++;
      if (wait_cnt >= ack_lat) begin
        step_ack = 1'b1;
        wait_cnt = 0;
      end
    end else if (!step_req && spurious && $urandom_range(0, 15) == 0) begin
      step_ack = 1'b1;
    end
    if (step_req && !prev_req) rises.push_back(vs_seen);
    prev_req = step_req;
    y = (int'(y) == LINES - 1) ? 10'd0 : y + 10'd1;
    if (int'(y) == V_ACTIVE) vs_seen++;
    if (rnd_bus) begin
      rd_addr_vid = ADDR_W'($urandom);
      addr_game   = ADDR_W'($urandom);
      we_game     = 1'($urandom);
      wdata_game  = DATA_W'($urandom);
      if ($urandom_range(0, 63) == 0) clr_overrun = 1'b1;
    end
  endtask

  task automatic run_lines(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_to_y(input int target);
    int n = 0;
    while (int'(y) != target && n < 2 * LINES) begin
      tick();
      n++;
    end
    chk("run_to_y_timeout", 32'(y), 32'(target));
  endtask

  task automatic wait_req();
    int n = 0;
    while (!step_req && n < 20 * LINES) begin
      tick();
      n++;
    end
    chk("step_req_timeout", 32'(step_req), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int exp_r[3];
    exp_r = '{3, 6, 9};
    reset = 1'b1; y = 10'd0; pause = 1'b0; speed = 4'd2; step_ack = 1'b0;
    clr_overrun = 1'b0; rd_addr_vid = 10'h055; addr_game = 10'h0AA;
    we_game = 1'b1; wdata_game = 4'h9;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    chk("rst_step_req",   32'(step_req),   32'd0);
    chk("rst_grant",      32'(grant),      32'd0);
    chk("rst_frame_cnt",  32'(frame_cnt),  32'd0);
    chk("rst_step_count", 32'(step_count), 32'd0);
    chk("rst_overrun",    32'(overrun),    32'd0);
    chk("rst_ram_we",     32'(ram_we),     32'd0);
    chk("rst_ram_addr",   32'(ram_addr),   32'h055);

    // Normal cadence: speed 2, ack 5 cycles after the request
    for (int f = 1; f <= 9; f++) begin
      run_lines(LINES);
      chk("cadence_frame_cnt", 32'(frame_cnt), 32'(f % 3));
    end
    chk("cadence_rises", 32'(rises.size()), 32'd3);
    for (int i = 0; i < 3 && i < rises.size(); i++)
      chk("cadence_rise_frame", 32'(rises[i]), 32'(exp_r[i]));
    chk("cadence_step_count", 32'(step_count), 32'd3);

    // Pause freezes the count
    run_lines(LINES);
    chk("pre_pause_frame_cnt", 32'(frame_cnt), 32'd1);
    pause = 1'b1;
    run_lines(4 * LINES);
    chk("pause_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("pause_no_req", 32'(rises.size()), 32'd3);
    pause = 1'b0;
    run_lines(LINES);
    chk("resume_frame_cnt", 32'(frame_cnt), 32'd2);
    run_lines(LINES);
    chk("resume_rises", 32'(rises.size()), 32'd4);
    if (rises.size() > 3) chk("resume_rise_frame", 32'(rises[3]), 32'd16);
    chk("resume_step_count", 32'(step_count), 32'd4);

    // RAM mux and overrun
    hold_ack = 1'b1;
    we_game = 1'b1; addr_game = 10'h03F; rd_addr_vid = 10'h012;
    tick();
    chk("mux_idle_addr", 32'(ram_addr), 32'h012);
    chk("mux_idle_we",   32'(ram_we),   32'd0);
    wait_req();
    chk("mux_step_addr", 32'(ram_addr), 32'h03F);
    chk("mux_step_we",   32'(ram_we),   32'd1);
    run_to_y(10);
    chk("ovr_set",        32'(overrun),    32'd1);
    chk("ovr_grant_held", 32'(grant),      32'd1);
    chk("ovr_count_held", 32'(step_count), 32'd4);
    hold_ack = 1'b0;
    run_lines(10);
    chk("ovr_ack_count", 32'(step_count), 32'd5);
    chk("ovr_ack_grant", 32'(grant),      32'd0);
    chk("ovr_sticky",    32'(overrun),    32'd1);
    clr_overrun = 1'b1;
    tick();
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Lowering speed below the current count fires at the next vblank
    speed = 4'd7;
    run_lines(5 * LINES);
    chk("speed_pre_cnt", 32'(frame_cnt), 32'd5);
    speed = 4'd1;
    r = rises.size();
    run_lines(LINES);
    chk("speed_low_rise", 32'(rises.size()), 32'(r + 1));
    chk("speed_low_cnt",  32'(frame_cnt),    32'd0);

    // Reset in the middle of a step during blanking
    speed = 4'd0;
    hold_ack = 1'b1;
    wait_req();
    run_to_y(500);
    chk("pre_reset_grant", 32'(grant), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    hold_ack = 1'b0;
    wait_cnt = 0;
    chk("mid_rst_step_req",   32'(step_req),   32'd0);
    chk("mid_rst_grant",      32'(grant),      32'd0);
    chk("mid_rst_step_count", 32'(step_count), 32'd0);
    chk("mid_rst_frame_cnt",  32'(frame_cnt),  32'd0);
    r = rises.size();
    run_to_y(V_ACTIVE - 1);
    chk("mid_rst_no_req", 32'(rises.size()), 32'(r));
    run_lines(4);
    chk("mid_rst_next_req", 32'(rises.size()), 32'(r + 1));

    // Randomized traffic
    rnd_bus  = 1'b1;
    spurious = 1'b1;
    for (int f = 0; f < 24; f++) begin
      int k;
      k       = $urandom_range(1, LINES - 1);
      pause   = ($urandom_range(0, 3) == 0);
      ack_lat = $urandom_range(1, 80);
      speed   = 4'($urandom_range(0, 3));
      run_lines(k);
      if ($urandom_range(0, 1) == 1) speed = 4'($urandom_range(0, 4));
      run_lines(LINES - k);
    end
    hold_ack = 1'b0;
    spurious = 1'b0;
    run_lines(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
